apb_uart_tx: RTL and testbench

- APB slave UART transmitter on the peripheral bus, at slave port 0 (base 16'h00C0, decoded by the interconnect).
- Consumes the interconnect's shared master-side signals: PADDR, PWRITE, PSEL, PENABLE, PWDATA, PRDATA, PREADY.
- Core writes bytes into a TX FIFO; a baud-rate FSM serialises them 8N1, LSB first, onto tx.
- Provides status and divisor registers, and stalls writes when the FIFO is full.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/apb_uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_apb_uart_tx.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the APB UART blocks: register map,
// STATUS bit layout and transmitter state encoding.
package uart_pkg;

  localparam logic [1:0] UART_REG_TXDATA = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;
  localparam logic [1:0] UART_REG_DIV    = 2'd2;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic logic [3:0] sat_cnt(input logic [31:0] c);
    return (c > 32'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with occupancy count; reused by the
// UART TX path and intended for a future RX block.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb_uart_tx.sv
// APB UART transmitter: TX FIFO + 8N1 serialiser (8E1 when
// UART_TX_PARITY_EN is defined), status and divisor registers.
module apb_uart_tx
  import uart_pkg::*;
#(
  parameter int BUS_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 434
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] PADDR,
  input  logic                 PWRITE,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic [BUS_WIDTH-1:0] PWDATA,
  output logic [BUS_WIDTH-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 tx,
  output logic                 irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam int DW = 15;
`else
  localparam int DW = 16;
`endif

  logic [1:0]           addr;
  logic                 acc;
  logic                 wr_tx;
  logic                 wr_div;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;
  logic [7:0]           fifo_rdata;
  logic [BUS_WIDTH-1:0] status;
  logic [DW-1:0]        div;
  logic [DW-1:0]        bit_len;
  logic [DW-1:0]        cnt;
  logic [7:0]           shift;
  logic [2:0]           bit_idx;
  logic                 par;
  logic                 bit_end;
  logic                 tx_n;
  tx_state_t            state;
  tx_state_t            state_n;
  logic                 unused;

  assign unused = ^{PADDR[BUS_WIDTH-1:2], PWDATA[BUS_WIDTH-1:8]};

  assign addr   = PADDR[1:0];
  assign acc    = PSEL & PENABLE;
  assign wr_tx  = acc & PWRITE & (addr == UART_REG_TXDATA);
  assign wr_div = acc & PWRITE & (addr == UART_REG_DIV);
  assign PREADY = ~(wr_tx & full);
  assign push   = wr_tx & PREADY;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (PWDATA[7:0]),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    status                      = '0;
    status[ST_FULL]             = full;
    status[ST_EMPTY]            = empty;
    status[ST_BUSY]             = (state != IDLE);
    status[ST_CNT_LSB +: 4]     = sat_cnt(32'(count));
  end

  always_comb begin
    PRDATA = '0;
    if (acc && !PWRITE) begin
      unique case (addr)
        UART_REG_STATUS: PRDATA = status;
        UART_REG_DIV:    PRDATA = BUS_WIDTH'(div);
        default:         PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= DW'(CLK_DIV);
    end else if (wr_div) begin
      div <= (PWDATA[DW-1:0] == '0) ? DW'(1) : PWDATA[DW-1:0];
    end
  end

  assign bit_end = (cnt == '0);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = 1'b1;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        tx_n = shift[0];
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
      PARITY: begin
        tx_n = par;
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The divisor is sampled per frame so DIV writes never stretch a live frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_len <= DW'(CLK_DIV);
      shift   <= '0;
      bit_idx <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
      irq     <= 1'b1;
    end else begin
      state <= state_n;
      tx    <= tx_n;
      irq   <= empty & (state == IDLE);
      if (pop) begin
        shift   <= fifo_rdata;
        par     <= ^fifo_rdata;
        bit_len <= div;
        cnt     <= div - DW'(1);
        bit_idx <= '0;
      end else if (state != IDLE) begin
        if (bit_end) begin
          cnt <= bit_len - DW'(1);
          if (state == DATA) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
        end else begin
          cnt <= cnt - DW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_uart_tx.sv
// Directed bench for apb_uart_tx: register vector table plus
// serial-frame sequences decoded by a bench-side UART receiver.
module tb_apb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
  localparam logic [15:0] DIV_MAX_RD = 16'h7FFF;
`else
  localparam int FB = 10;
  localparam logic [15:0] DIV_MAX_RD = 16'hFFFF;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [15:0] PWDATA;
  logic [15:0] PRDATA;
  logic        PREADY;
  logic        tx;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int tb_div = 4;

  logic [7:0] rxq[$];
  int         rxt[$];
  logic       parq[$];

  apb_uart_tx dut (
    .clk     (clk),
    .reset   (reset),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .tx      (tx),
    .irq     (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Bench-side receiver, samples mid-bit using tb_div
  initial begin : rx_mon
    int d;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset && tx === 1'b0) begin
        rxt.push_back(cyc);
        d = tb_div;
        b = '0;
        repeat (d / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (d) @(negedge clk);
          b[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (d) @(negedge clk);
        parq.push_back(tx);
`endif
        repeat (d) @(negedge clk);
        chk("stop_bit", tx, 1'b1);
        rxq.push_back(b);
      end
    end
  end

  task automatic apb_write(input logic [1:0] a, input logic [15:0] d,
                           output int cc);
    int w;
    PADDR = {14'b0, a}; PWDATA = d; PWRITE = 1'b1;
    PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1 PENABLE = 1'b1;
    w = 0;
    @(negedge clk);
    while (!PREADY && w < 2000) begin
      w++;
      @(negedge clk);
    end
    if (w >= 2000) chk("pready_timeout", PREADY, 1'b1);
    @(posedge clk); #1;
    cc = cyc;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [15:0] d);
    PADDR = {14'b0, a}; PWRITE = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge clk);
    chk("prdata_setup_zero", PRDATA, 16'h0);
    @(posedge clk); #1 PENABLE = 1'b1;
    @(negedge clk);
    d = PRDATA;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int w;
    w = 0;
    while (rxq.size() < n && w < 5000) begin
      @(posedge clk);
      w++;
    end
    #1;
    if (rxq.size() < n) chk("rx_timeout", rxq.size(), n);
  endtask

  task automatic rx_clear();
    rxq.delete();
    rxt.delete();
    parq.delete();
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[14];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] r;
    logic [10:0] ebits;
    logic        v;
    int c, c0, e0, p, lows;

    vt[0]  = '{1'b0, 2'd1, 16'h0000, 16'h0002};
    vt[1]  = '{1'b0, 2'd2, 16'h0000, 16'd434};
    vt[2]  = '{1'b0, 2'd0, 16'h0000, 16'h0000};
    vt[3]  = '{1'b0, 2'd3, 16'h0000, 16'h0000};
    vt[4]  = '{1'b1, 2'd3, 16'h1234, 16'h0000};
    vt[5]  = '{1'b0, 2'd3, 16'h0000, 16'h0000};
    vt[6]  = '{1'b1, 2'd1, 16'hFFFF, 16'h0000};
    vt[7]  = '{1'b0, 2'd1, 16'h0000, 16'h0002};
    vt[8]  = '{1'b1, 2'd2, 16'hFFFF, 16'h0000};
    vt[9]  = '{1'b0, 2'd2, 16'h0000, DIV_MAX_RD};
    vt[10] = '{1'b1, 2'd2, 16'h0000, 16'h0000};
    vt[11] = '{1'b0, 2'd2, 16'h0000, 16'h0001};
    vt[12] = '{1'b1, 2'd2, 16'h0004, 16'h0000};
    vt[13] = '{1'b0, 2'd2, 16'h0000, 16'h0004};

    reset = 1'b0; PADDR = '0; PWRITE = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWDATA = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_irq", irq, 1'b1);
    chk("rst_pready", PREADY, 1'b1);
    chk("rst_prdata", PRDATA, 16'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_tx", tx, 1'b1);
    chk("post_rst_irq", irq, 1'b1);
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      if (vt[i].wr) begin
        apb_write(vt[i].addr, vt[i].wdata, c);
      end else begin
        apb_read(vt[i].addr, r);
        chk($sformatf("vec%0d", i), r, vt[i].exp);
      end
    end

    // Single byte A5, bit-by-bit
    tb_div = 4;
    rx_clear();
    ebits = '1;
    ebits[0] = 1'b0;
    ebits[8:1] = 8'hA5;
`ifdef UART_TX_PARITY_EN
    ebits[9] = ^8'hA5;
`endif
    apb_write(2'd0, 16'h00A5, c);
    @(negedge clk);
    chk("a5_lat0", tx, 1'b1);
    @(negedge clk);
    chk("a5_lat1", tx, 1'b1);
    chk("a5_irq_busy", irq, 1'b0);
    for (int k = 0; k < FB; k++) begin
      v = ebits[k];
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        if (tx !== ebits[k]) v = tx;
      end
      chk($sformatf("a5_bit%0d", k), v, ebits[k]);
    end
    @(negedge clk);
    chk("a5_irq_done", irq, 1'b1);
    @(posedge clk); #1;

    // Full FIFO stall: 10 writes back to back
    rx_clear();
    e0 = 0;
    for (int i = 0; i < 10; i++) begin
      apb_write(2'd0, 16'h0010 + 16'(i), c);
      if (i == 0) e0 = c;
    end
    chk("stall_commit", c, e0 + 2 + FB * 4);
    wait_rx(10);
    if (rxq.size() == 10) begin
      chk("stall_first_start", rxt[0], e0 + 2);
      for (int i = 0; i < 10; i++)
        chk($sformatf("stall_byte%0d", i), rxq[i], 8'h10 + 8'(i));
      for (int i = 1; i < 10; i++)
        chk($sformatf("stall_gap%0d", i), rxt[i] - rxt[i-1], FB * 4);
    end
    repeat (60) @(posedge clk);
    #1;
    chk("stall_no_dup", rxq.size(), 10);

    // Push on the exact pop edge with count=3
    rx_clear();
    apb_write(2'd0, 16'h0021, c0);
    apb_write(2'd0, 16'h0022, c);
    apb_write(2'd0, 16'h0023, c);
    apb_write(2'd0, 16'h0024, c);
    apb_read(2'd1, r);
    chk("sim_status_pre", r, 16'h0034);
    p = c0 + 1 + FB * 4;
    while (cyc < p - 2) begin
      @(posedge clk); #1;
    end
    apb_write(2'd0, 16'h0025, c);
    chk("sim_commit_edge", c, p);
    apb_read(2'd1, r);
    chk("sim_status_post", r, 16'h0034);
    wait_rx(5);
    for (int i = 0; i < 5; i++)
      if (i < rxq.size())
        chk($sformatf("sim_byte%0d", i), rxq[i], 8'h21 + 8'(i));
    repeat (50) @(posedge clk);
    #1;

    // DIV change mid-frame, then DIV=0 -> 1-cycle bits
    rx_clear();
    apb_write(2'd0, 16'h005A, c);
    apb_write(2'd2, 16'h0008, c);
    wait_rx(1);
    chk("div_mid_byte", rxq[0], 8'h5A);
    repeat (10) @(posedge clk);
    #1;
    tb_div = 8;
    apb_write(2'd0, 16'h00C3, c);
    wait_rx(2);
    chk("div8_byte", rxq[1], 8'hC3);
    chk("div8_latency", rxt[1], c + 2);
    repeat (20) @(posedge clk);
    #1;
    apb_write(2'd2, 16'h0000, c);
    apb_read(2'd2, r);
    chk("div0_read", r, 16'h0001);
    tb_div = 1;
    apb_write(2'd0, 16'h0096, c);
    wait_rx(3);
    chk("div1_byte", rxq[2], 8'h96);
    chk("div1_latency", rxt[2], c + 2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("div1_irq", irq, 1'b1);
    @(posedge clk); #1;

`ifdef UART_TX_PARITY_EN
    rx_clear();
    apb_write(2'd2, 16'h0004, c);
    tb_div = 4;
    apb_write(2'd0, 16'h0007, c);
    wait_rx(1);
    chk("par_byte", rxq[0], 8'h07);
    if (parq.size() > 0) chk("par_bit", parq[0], 1'b1);
    repeat (10) @(posedge clk);
    #1;
`endif

    // Async reset during DATA bit 3 (tx low)
    apb_write(2'd2, 16'h0004, c);
    tb_div = 4;
    rx_clear();
    apb_write(2'd0, 16'h00F7, c);
    while (cyc < c + 19) @(negedge clk);
    chk("rst_mid_pre_tx", tx, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_mid_tx", tx, 1'b1);
    chk("rst_mid_irq", irq, 1'b1);
    chk("rst_mid_pready", PREADY, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    apb_read(2'd1, r);
    chk("rst_mid_status", r, 16'h0002);
    apb_read(2'd2, r);
    chk("rst_mid_div", r, 16'd434);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("rst_mid_no_resume", lows, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
